// File: rtl/tile_reader.sv
// ============================================================================
// tile_reader
// ----------------------------------------------------------------------------
// Reads one 5x5 cell of a pixel framebuffer and rebuilds it as a 25-bit
// bitmap. A cell at grid position (x_in, y_in) covers the pixels whose
// top-left corner is (x_in*5, y_in*5). Both coordinates are truncated to the
// width of the framebuffer address ports, so cells at the right and bottom
// edges wrap around silently.
//
// Operation: IDLE -> READ (25 reads, one per cycle, row-major) -> DRAIN
// (waits READ_LATENCY cycles for the last samples to return) -> DONE (one
// cycle done pulse, results published) -> IDLE.
//
// Parameters
//   READ_LATENCY   cycles from rd_en to valid rd_data; legal values 1..3
//
// Configuration macro
//   TILE_READER_MATCH_EN
//     defined   : a pixel is set when rd_data == match_colour
//     undefined : a pixel is set when rd_data != 0 (match_colour ignored)
//
// Ports
//   clock         in   1   system clock, rising edge
//   reset_n       in   1   synchronous, active-low reset
//   start         in   1   request to read one cell (accepted only in IDLE)
//   x_in          in   8   grid column of the cell
//   y_in          in   7   grid row of the cell
//   match_colour  in   3   colour that counts as a set pixel
//   rd_en         out  1   framebuffer read strobe
//   rd_x          out  8   pixel x of the read (holds when rd_en is low)
//   rd_y          out  7   pixel y of the read (holds when rd_en is low)
//   rd_data       in   3   pixel colour, valid READ_LATENCY cycles after rd_en
//   busy          out  1   high while reading or draining
//   done          out  1   one-cycle completion pulse
//   shape         out  25  bitmap; pixel k = 5*row + col lands in shape[24-k]
//   any_hit       out  1   OR of all shape bits
// ============================================================================
module tile_reader #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  x_in,
    input  logic [6:0]  y_in,
    input  logic [2:0]  match_colour,
    output logic        rd_en,
    output logic [7:0]  rd_x,
    output logic [6:0]  rd_y,
    input  logic [2:0]  rd_data,
    output logic        busy,
    output logic        done,
    output logic [24:0] shape,
    output logic        any_hit
);

    localparam logic [4:0] LAST_PIXEL = 5'd24;
    localparam logic [2:0] LAST_COL   = 3'd4;
    localparam logic [1:0] DRAIN_LAST = 2'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    // Control decoded from the current state.
    logic        accept;        // start taken this cycle
    logic        publish;       // last DRAIN cycle: results move to shape

    // Cell origin and scan position.
    logic [7:0]  base_x;
    logic [6:0]  base_y;
    logic [2:0]  col;
    logic [2:0]  row;
    logic [4:0]  pixel_idx;     // 5*row + col of the read being issued
    logic [1:0]  drain_cnt;

    // Issue tags travelling alongside the framebuffer latency, so each
    // returning sample knows which bitmap bit it belongs to.
    logic        pipe_valid [READ_LATENCY];
    logic [4:0]  pipe_idx   [READ_LATENCY];

    logic        sample_bit;
    logic [24:0] assembly;      // bitmap under construction
    logic [24:0] assembly_next;

    // ------------------------------------------------------------------------
    // Pixel classification
    // ------------------------------------------------------------------------
`ifdef TILE_READER_MATCH_EN
    assign sample_bit = (rd_data == match_colour);
`else
    assign sample_bit = (rd_data != 3'b000);

    // match_colour has no function in this build.
    logic unused_match_colour;
    assign unused_match_colour = ^match_colour;
`endif

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // NOTE: every clocked process uses non-blocking assignments so all
    // registers update from the same pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        publish    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = READ;
                end
            end
            READ: begin
                rd_en = 1'b1;
                busy  = 1'b1;
                if (pixel_idx == LAST_PIXEL) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == DRAIN_LAST) begin
                    publish    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                // start is deliberately not looked at here; a held start is
                // taken on the following IDLE cycle.
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Scan counters and cell origin
    // ------------------------------------------------------------------------
    // The counters stop on the last pixel instead of wrapping, so rd_x/rd_y
    // keep showing the final address while rd_en is low.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            base_x    <= '0;
            base_y    <= '0;
            col       <= '0;
            row       <= '0;
            pixel_idx <= '0;
            drain_cnt <= '0;
        end else if (accept) begin
            // The products are taken at port width, which is the intended
            // modulo-256 / modulo-128 wrap.
            base_x    <= x_in * 8'd5;
            base_y    <= y_in * 7'd5;
            col       <= '0;
            row       <= '0;
            pixel_idx <= '0;
            drain_cnt <= '0;
        end else begin
            if (state == READ && pixel_idx != LAST_PIXEL) begin
                pixel_idx <= pixel_idx + 5'd1;
                if (col == LAST_COL) begin
                    col <= '0;
                    row <= row + 3'd1;
                end else begin
                    col <= col + 3'd1;
                end
            end
            if (state == DRAIN) begin
                drain_cnt <= drain_cnt + 2'd1;
            end
        end
    end

    assign rd_x = base_x + {5'b00000, col};
    assign rd_y = base_y + {4'b0000, row};

    // ------------------------------------------------------------------------
    // Issue-tag pipeline matching the framebuffer latency
    // ------------------------------------------------------------------------
    // NOTE: this small pipeline is reset on purpose: clearing the valid bits
    // is what throws away samples still in flight when reset hits mid-read.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_idx[i]   <= '0;
            end
        end else begin
            pipe_valid[0] <= rd_en;
            pipe_idx[0]   <= pixel_idx;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_idx[i]   <= pipe_idx[i-1];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Bitmap assembly
    // ------------------------------------------------------------------------
    // The newest sample is merged combinationally so the final bitmap can be
    // published on the same edge that captures the last returning pixel.
    always_comb begin
        assembly_next = assembly;
        if (pipe_valid[READ_LATENCY-1]) begin
            assembly_next[LAST_PIXEL - pipe_idx[READ_LATENCY-1]] = sample_bit;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            assembly <= '0;
        end else if (accept) begin
            assembly <= '0;
        end else begin
            assembly <= assembly_next;
        end
    end

    // Published results only change on entry to DONE and hold until the next
    // operation completes, whatever happens to the assembly register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            shape   <= '0;
            any_hit <= 1'b0;
        end else if (publish) begin
            shape   <= assembly_next;
            any_hit <= |assembly_next;
        end
    end

endmodule
